// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared defaults and sweep/run state encoding for the memory responder
package mem_resp_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 2048;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - DEPTH x DATA_W storage, two asynchronous read ports, one synchronous write port
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int IDX_W  = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [IDX_W-1:0]  raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - instruction/data memory responder with clear sweep, loader port and range checks
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] I_ADDR,
  input  logic              im_oen,
  output logic [DATA_W-1:0] IR,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic              dm_oen,
  input  logic              dm_wen,
  input  logic [DATA_W-1:0] D_OUT,
  output logic [DATA_W-1:0] D_IN,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy,
  output logic              oob_err
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] ir_q, ir_d, din_q, din_d;
  logic              oob_q, oob_d;

  logic              run, i_ok, d_ok, l_ok;
  logic              ld_acc, pw, lw;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata, rd_a, rd_b;

  assign run      = (state_q == ST_RUN);
  assign i_ok     = in_range(I_ADDR);
  assign d_ok     = in_range(D_ADDR);
  assign l_ok     = in_range(ld_addr);
  assign ld_ready = run & dm_wen;
  assign ld_acc   = ld_valid & ld_ready;
  assign pw       = run & ~dm_wen & d_ok;
  assign lw       = ld_acc & l_ok;

  assign busy    = ~run;
  assign IR      = ir_q;
  assign D_IN    = din_q;
  assign oob_err = oob_q;

  // Single write port: sweep owns it in CLEAR, processor store beats loader in RUN.
  always_comb begin
    we    = 1'b0;
    waddr = cnt_q[IDX_W-1:0];
    wdata = '0;
    if (!run) begin
      we = 1'b1;
    end else if (pw) begin
      we    = 1'b1;
      waddr = D_ADDR[IDX_W-1:0];
      wdata = D_OUT;
    end else if (lw) begin
      we    = 1'b1;
      waddr = ld_addr[IDX_W-1:0];
      wdata = ld_data;
    end
  end

  mem_resp_array #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk       (clk),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (I_ADDR[IDX_W-1:0]),
    .rdata_a_o (rd_a),
    .raddr_b_i (D_ADDR[IDX_W-1:0]),
    .rdata_b_o (rd_b)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    din_d   = din_q;
    oob_d   = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        ir_d  = '0;
        din_d = '0;
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_C) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        // Reads see the word being written on the same edge (write-first).
        if (!im_oen) begin
          if (!i_ok) begin
            ir_d = '0;
          end else if (pw && (I_ADDR == D_ADDR)) begin
            ir_d = D_OUT;
          end else if (lw && (I_ADDR == ld_addr)) begin
            ir_d = ld_data;
          end else begin
            ir_d = rd_a;
          end
        end
        if (!dm_oen) begin
          if (!d_ok) begin
            din_d = '0;
          end else if (!dm_wen) begin
            din_d = D_OUT;
          end else if (lw && (D_ADDR == ld_addr)) begin
            din_d = ld_data;
          end else begin
            din_d = rd_b;
          end
        end
        oob_d = (~im_oen & ~i_ok) | ((~dm_oen | ~dm_wen) & ~d_ok) | (ld_acc & ~l_ok);
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ir_q    <= '0;
      din_q   <= '0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      din_q   <= din_d;
      oob_q   <= oob_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized scoreboard bench for mem_responder against a write-then-read memory model
module tb_mem_responder;

  localparam int AW  = 11;
  localparam int IW  = 10;
  localparam int DW  = 32;
  localparam int DEP = 1024;

  logic          clk, rst;
  logic [AW-1:0] I_ADDR, D_ADDR, ld_addr;
  logic          im_oen, dm_oen, dm_wen, ld_valid;
  logic [DW-1:0] D_OUT, ld_data, IR, D_IN;
  logic          ld_ready, busy, oob_err;

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clk      (clk),
    .rst      (rst),
    .I_ADDR   (I_ADDR),
    .im_oen   (im_oen),
    .IR       (IR),
    .D_ADDR   (D_ADDR),
    .dm_oen   (dm_oen),
    .dm_wen   (dm_wen),
    .D_OUT    (D_OUT),
    .D_IN     (D_IN),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .busy     (busy),
    .oob_err  (oob_err)
  );

  typedef struct packed {
    logic [DW-1:0] ir;
    logic [DW-1:0] din;
    logic          oob;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mdl [DEP];
  logic [DW-1:0] ir_m, din_m;
  int            total = 0;
  int            bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard monitor: one expected entry per clock edge that carried stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("IR", IR, e.ir);
        chk("D_IN", D_IN, e.din);
        chk("oob_err", {31'b0, oob_err}, {31'b0, e.oob});
      end
    end
  end

  task automatic idle();
    im_oen = 1'b1; dm_oen = 1'b1; dm_wen = 1'b1; ld_valid = 1'b0;
    I_ADDR = '0; D_ADDR = '0; D_OUT = '0; ld_addr = '0; ld_data = '0;
  endtask

  // Called at a falling edge: drive, predict the next rising edge, move to the next falling edge.
  task automatic step(input logic [AW-1:0] ia, input logic ioen,
                      input logic [AW-1:0] da, input logic doen, input logic dwen,
                      input logic [DW-1:0] dout,
                      input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    exp_t e;
    bit   i_ok, d_ok, l_ok, ld_take;
    I_ADDR = ia; im_oen = ioen; D_ADDR = da; dm_oen = doen; dm_wen = dwen;
    D_OUT = dout; ld_valid = lv; ld_addr = la; ld_data = ld;
    i_ok    = int'(ia) < DEP;
    d_ok    = int'(da) < DEP;
    l_ok    = int'(la) < DEP;
    ld_take = lv && dwen;
    if (!dwen) begin
      if (d_ok) mdl[da[IW-1:0]] = dout;
    end else if (ld_take && l_ok) begin
      mdl[la[IW-1:0]] = ld;
    end
    if (!ioen) ir_m = i_ok ? mdl[ia[IW-1:0]] : '0;
    if (!doen) din_m = d_ok ? mdl[da[IW-1:0]] : '0;
    e.ir  = ir_m;
    e.din = din_m;
    e.oob = (!ioen && !i_ok) || ((!doen || !dwen) && !d_ok) || (ld_take && !l_ok);
    exp_q.push_back(e);
    #1;
    chk("ld_ready", {31'b0, ld_ready}, {31'b0, dwen});
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5) return AW'($urandom_range(0, 7));
    if (r <= 7) return AW'($urandom_range(0, DEP - 1));
    if (r == 8) return AW'($urandom_range(DEP - 4, DEP + 4));
    return AW'($urandom_range(0, 2 ** AW - 1));
  endfunction

  // Starts just after rst falls at a falling edge; processor traffic must be ignored.
  task automatic sweep_check();
    int n;
    bit io_bad;
    n = 0;
    io_bad = 1'b0;
    while (busy && n < DEP + 20) begin
      im_oen = 1'b0; dm_oen = 1'b0; dm_wen = 1'($urandom_range(0, 1));
      I_ADDR = rnd_addr(); D_ADDR = rnd_addr(); D_OUT = $urandom();
      @(posedge clk);
      #1;
      n++;
      if (IR !== '0 || D_IN !== '0 || oob_err !== 1'b0) io_bad = 1'b1;
    end
    idle();
    chk("busy_cycles", DW'(n), DW'(DEP));
    chk("sweep_outputs_zero", {31'b0, io_bad}, 32'd0);
    #1;
    chk("ld_ready_after_sweep", {31'b0, ld_ready}, 32'd1);
    for (int i = 0; i < DEP; i++) mdl[i] = '0;
    ir_m  = '0;
    din_m = '0;
    @(negedge clk);
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      step(rnd_addr(), 1'($urandom_range(0, 2) == 0 ? 1 : 0),
           rnd_addr(), 1'($urandom_range(0, 2) == 0 ? 1 : 0),
           1'($urandom_range(0, 2) != 0 ? 1 : 0), $urandom(),
           1'($urandom_range(0, 1)), rnd_addr(), $urandom());
    end
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_IR", IR, '0);
    chk("rst_D_IN", D_IN, '0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("rst_oob", {31'b0, oob_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sweep_check();

    // cleared memory reads zero at both ends
    step(11'd5, 1'b0, 11'd1023, 1'b0, 1'b1, '0, 1'b0, '0, '0);
    // loader word, then fetch; a concurrent store blocks the loader
    step('0, 1'b1, '0, 1'b1, 1'b1, '0, 1'b1, 11'd5, 32'h1111_1111);
    step(11'd5, 1'b0, 11'd20, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 11'd6, 32'h6666_6666);
    step(11'd6, 1'b0, '0, 1'b1, 1'b1, '0, 1'b0, '0, '0);
    step(11'd6, 1'b0, 11'd20, 1'b0, 1'b1, '0, 1'b1, 11'd6, 32'h6666_6666);
    step(11'd6, 1'b0, '0, 1'b1, 1'b1, '0, 1'b0, '0, '0);
    // store/fetch bypass, then data read back
    step(11'd9, 1'b0, 11'd9, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, '0, '0);
    step('0, 1'b1, 11'd9, 1'b0, 1'b1, '0, 1'b0, '0, '0);
    // write-first on the data port
    step('0, 1'b1, 11'd3, 1'b0, 1'b0, 32'hA5A5_A5A5, 1'b0, '0, '0);
    step(11'd3, 1'b0, 11'd3, 1'b0, 1'b1, '0, 1'b0, '0, '0);
    // out-of-range store, read, fetch and loader transfer; aliased word untouched
    step('0, 1'b1, 11'd1500, 1'b1, 1'b0, 32'h1234_5678, 1'b0, '0, '0);
    step('0, 1'b1, 11'd476, 1'b0, 1'b1, '0, 1'b0, '0, '0);
    step(11'd2047, 1'b0, 11'd1500, 1'b0, 1'b1, '0, 1'b0, '0, '0);
    step('0, 1'b1, '0, 1'b1, 1'b1, '0, 1'b1, 11'd1024, 32'h7777_7777);
    step(11'd1023, 1'b0, 11'd1023, 1'b0, 1'b0, 32'hFEED_0001, 1'b0, '0, '0);
    step(11'd0, 1'b0, 11'd0, 1'b1, 1'b1, '0, 1'b0, '0, '0);

    random_phase(1500);

    // asynchronous reset mid-run with nonzero outputs
    step(11'd7, 1'b0, 11'd7, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0, '0, '0);
    chk("pre_rst_IR", IR, 32'hCAFE_F00D);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_IR", IR, '0);
    chk("mid_rst_D_IN", D_IN, '0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd1);
    chk("mid_rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sweep_check();

    step(11'd7, 1'b0, 11'd9, 1'b0, 1'b1, '0, 1'b0, '0, '0);
    step(11'd5, 1'b0, 11'd3, 1'b0, 1'b1, '0, 1'b0, '0, '0);
    step(11'd1023, 1'b0, 11'd6, 1'b0, 1'b1, '0, 1'b0, '0, '0);
    random_phase(300);

    idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", DW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 11, word address width of both ports.
REQ-002 Parameter DATA_W, default 32, word width.
REQ-003 Parameter DEPTH, default 2048, implemented words; DEPTH SHALL be at most 2^ADDR_W.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-high.
REQ-006 I_ADDR  input  ADDR_W  instruction fetch address.
REQ-007 im_oen  input  1  instruction read enable, active-low.
REQ-008 IR  output  DATA_W  instruction read data, registered.
REQ-009 D_ADDR  input  ADDR_W  data access address.
REQ-010 dm_oen  input  1  data read enable, active-low.
REQ-011 dm_wen  input  1  data write enable, active-low.
REQ-012 D_OUT  input  DATA_W  data to be written (processor's store data).
REQ-013 D_IN  output  DATA_W  data read result, registered.
REQ-014 ld_valid / ld_ready  input / output  1 / 1  program-loader handshake.
REQ-015 ld_addr / ld_data  input  ADDR_W / DATA_W  loader word address and data.
REQ-016 busy  output  1  high while memory clear sweep runs.
REQ-017 oob_err  output  1  one-cycle pulse on any out-of-range access.

Function
REQ-018 States: CLEAR (sweep) and RUN; rst forces CLEAR; CLEAR goes to RUN on the cycle after word DEPTH-1 is written.
REQ-019 CLEAR: one word per cycle, counter 0..DEPTH-1, word written 0; busy=1, ld_ready=0, processor ports ignored, IR/D_IN held at 0.
REQ-020 RUN, im_oen=0: IR <= mem[I_ADDR] at the edge (1-cycle latency); im_oen=1: IR holds.
REQ-021 RUN, dm_wen=0: mem[D_ADDR] <= D_OUT at the edge.
REQ-022 RUN, dm_oen=0 and dm_wen=1: D_IN <= mem[D_ADDR] (1-cycle latency); dm_oen=1: D_IN holds.
REQ-023 dm_oen=0 and dm_wen=0 together: write occurs, D_IN <= D_OUT (write-first).
REQ-024 Data write and instruction read to same address same edge: IR <= D_OUT (write-first bypass).
REQ-025 ld_ready = 1 in RUN when dm_wen=1, else 0; word accepted when ld_valid & ld_ready at the edge: mem[ld_addr] <= ld_data.
REQ-026 Loader write and instruction read to same address same edge: IR <= ld_data.
REQ-027 Address >= DEPTH: read returns 0, write dropped, loader transfer consumed and dropped; oob_err=1 next cycle, any port.
REQ-028 Read-only storage access never alters memory; one write port in use per edge (processor priority over loader per REQ-025).

Reset
REQ-029 rst asserted: IR=0, D_IN=0, oob_err=0, ld_ready=0, busy=1, sweep counter=0, state=CLEAR, immediately (asynchronous).
REQ-030 rst asserted mid-sweep or mid-RUN: sweep restarts from word 0; any write at that edge is not guaranteed; contents guaranteed zero only after sweep completes.
REQ-031 rst deassertion: first sweep write on the first rising edge with rst low.

Structure
REQ-032 Package mem_resp_pkg SHALL hold ADDR_W/DATA_W/DEPTH defaults and the CLEAR/RUN state enum.
REQ-033 Storage SHALL be sub-module mem_resp_array: DEPTH x DATA_W, two asynchronous read ports, one synchronous write port; sweep, arbitration, bypass and range checks remain in mem_responder.

Verification
REQ-034 Release rst, DEPTH=2048: busy=1 for exactly 2048 cycles, then 0; ld_ready rises same cycle; read of any address returns 0.
REQ-035 Load 0x11111111 at addr 5 via loader, then im_oen=0, I_ADDR=5 -> IR=0x11111111 one cycle later; dm_wen=0 that cycle -> ld_ready=0, word not accepted until released.
REQ-036 dm_wen=0, D_ADDR=9, D_OUT=0xDEADBEEF with im_oen=0, I_ADDR=9 same edge -> IR=0xDEADBEEF; next dm_oen=0, D_ADDR=9 -> D_IN=0xDEADBEEF.
REQ-037 dm_oen=0, dm_wen=0, D_ADDR=3, D_OUT=0xA5A5A5A5 -> D_IN=0xA5A5A5A5 next cycle and mem[3]=0xA5A5A5A5.
REQ-038 DEPTH=1024, dm_wen=0 at D_ADDR=1500 -> oob_err one-cycle pulse, no word modified; read of 1500 -> D_IN=0.
REQ-039 rst pulsed mid-RUN after writes -> IR=D_IN=0 immediately, busy=1 for full sweep, previously written words read 0 afterwards.
